// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed 4-digit scanner for the clock display.
// A shadow register latches the display inputs once per frame, so a frame
// never mixes digits from two different times. One digit position is
// presented per slot. Each slot opens with an all-anodes-off blank window.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   digits_in    {hours_tens, hours_units, min_tens, min_units}, BCD
//   am_pm        0 = AM, 1 = PM
//   show_ampm    0 = time page, 1 = AM/PM page
//   lz_blank_en  blank hours_tens when it is zero
//   bcd_out      code to the 7-segment decoder (4'hA = blank)
//   an_n         active-low anode selects, bit 3 = leftmost digit
//   frame_start  one-cycle pulse in the first cycle of slot 3
module display_scan_mux #(
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] digits_in,
    input  logic        am_pm,
    input  logic        show_ampm,
    input  logic        lz_blank_en,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an_n,
    output logic        frame_start
);

    localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(1);
    localparam logic [3:0]    CODE_BLANK = 4'hA;
    localparam logic [3:0]    CODE_AM    = 4'hE;
    localparam logic [3:0]    CODE_PM    = 4'hF;

    typedef struct packed {
        logic [15:0] digits;
        logic        am_pm;
        logic        show_ampm;
        logic        lz_blank_en;
    } shadow_t;

    // armed is clear for the single cycle after reset release. Holding the
    // counters in that cycle lets the registered frame_start come up in the
    // opening cnt==0 cycle of slot 3.
    logic          armed,  armed_nxt;
    logic [CW-1:0] cnt,    cnt_nxt;
    logic [1:0]    idx,    idx_nxt;
    shadow_t       shadow, shadow_nxt;

    logic [3:0] bcd_nxt;
    logic [3:0] an_nxt;
    logic       frame_nxt;
    logic [3:0] field;
    logic [3:0] sel_code;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed  <= 1'b0;
            cnt    <= '0;
            idx    <= 2'd3;
            shadow <= '0;
        end else begin
            armed  <= armed_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shadow <= shadow_nxt;
        end
    end

    // Next state: slot counter, digit index, frame-boundary shadow capture
    always_comb begin
        armed_nxt  = 1'b1;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        shadow_nxt = shadow;
        if (armed) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                idx_nxt = idx - 2'd1;   // 0 wraps back to 3
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
            if ((cnt == '0) && (idx == 2'd3)) begin
                shadow_nxt.digits      = digits_in;
                shadow_nxt.am_pm       = am_pm;
                shadow_nxt.show_ampm   = show_ampm;
                shadow_nxt.lz_blank_en = lz_blank_en;
            end
        end
    end

    // Decoder code for the current slot, taken from the shadow
    always_comb begin
        case (idx)
            2'd3:    field = shadow.digits[15:12];
            2'd2:    field = shadow.digits[11:8];
            2'd1:    field = shadow.digits[7:4];
            default: field = shadow.digits[3:0];
        endcase
        sel_code = field;
        if (shadow.show_ampm) begin
            if (idx == 2'd0) begin
                sel_code = shadow.am_pm ? CODE_PM : CODE_AM;
            end else begin
                sel_code = CODE_BLANK;
            end
        end else if (field > 4'd9) begin
            sel_code = CODE_BLANK;
        end else if ((idx == 2'd3) && shadow.lz_blank_en && (field == 4'd0)) begin
            sel_code = CODE_BLANK;
        end
    end

    // Output next values. They are computed from next state, so each
    // registered output lines up with the cycle it describes.
    always_comb begin
        bcd_nxt = bcd_out;
        if (cnt == CNT_LOAD) begin
            bcd_nxt = sel_code;
        end
        an_nxt = 4'b1111;
        if (cnt_nxt >= CNT_BLANK) begin
            an_nxt[idx_nxt] = 1'b0;
        end
        frame_nxt = (cnt_nxt == '0) && (idx_nxt == 2'd3);
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_out     <= CODE_BLANK;
            an_n        <= 4'b1111;
            frame_start <= 1'b0;
        end else begin
            bcd_out     <= bcd_nxt;
            an_n        <= an_nxt;
            frame_start <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Testbench for display_scan_mux. It uses SLOT_CYCLES=8 and BLANK_CYCLES=3.
// The reference model tracks position in the frame from the frame_start
// pulse. It derives the expected codes from the inputs latched at the frame
// boundary.
module tb_display_scan_mux;

    localparam int unsigned SLOT  = 8;
    localparam int unsigned BLANK = 3;
    localparam int unsigned FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic        am_pm = 1'b0;
    logic        show_ampm = 1'b0;
    logic        lz_blank_en = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  an_n;
    logic        frame_start;

    display_scan_mux #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .am_pm(am_pm),
        .show_ampm(show_ampm), .lz_blank_en(lz_blank_en), .bcd_out(bcd_out),
        .an_n(an_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] digits;
        logic        am;
        logic        show;
        logic        lz;
    } stim_t;

    int checks = 0;
    int failures = 0;

    stim_t      model_sh;
    logic [3:0] cur_bcd = 4'hA;
    bit         at_p0 = 1'b0;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic [15:0] d, input logic am, input logic show, input logic lz);
        stim_t s;
        s.digits = d; s.am = am; s.show = show; s.lz = lz;
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        logic [15:0] d;
        d = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
             4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
        if ($urandom_range(0, 2) == 0) d[15:12] = 4'h0;
        return mk(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)));
    endfunction

    // Expected decoder code for a slot, straight from the display rules
    function automatic logic [3:0] exp_code(input int slot, input stim_t s);
        logic [3:0] d;
        if (s.show) return (slot == 0) ? (s.am ? 4'hF : 4'hE) : 4'hA;
        d = 4'((s.digits >> (4 * slot)) & 16'hF);
        if (d > 4'd9) return 4'hA;
        if (slot == 3 && s.lz && d == 4'd0) return 4'hA;
        return d;
    endfunction

    task automatic apply(input stim_t s);
        digits_in = s.digits; am_pm = s.am; show_ampm = s.show; lz_blank_en = s.lz;
    endtask

    // Wait (bounded) for the frame_start pulse; leaves us at frame cycle 0
    task automatic sync_frame();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                at_p0 = 1'b1;
                cur_bcd = 4'hA;
                return;
            end
        end
        check("sync_timeout", 4'h0, 4'h1);
    endtask

    // One frame: s is applied for capture at cycle 0, junk is driven at
    // cycle junk_p, and reset is asserted at cycle rst_p (if >= 0).
    task automatic run_frame(input stim_t s, input int junk_p, input stim_t junk, input int rst_p);
        int slot;
        int c;
        logic [3:0] exp_an;
        for (int p = 0; p < FRAME; p++) begin
            if (!(p == 0 && at_p0)) @(negedge clk);
            at_p0 = 1'b0;
            slot = 3 - p / SLOT;
            c = p % SLOT;
            if (c == 2) cur_bcd = exp_code(slot, model_sh);
            exp_an = 4'hF;
            if (c >= BLANK) exp_an[slot] = 1'b0;
            check($sformatf("frame_start p%0d", p), {3'b000, frame_start}, (p == 0) ? 4'h1 : 4'h0);
            check($sformatf("an_n p%0d", p), an_n, exp_an);
            check($sformatf("bcd_out p%0d", p), bcd_out, cur_bcd);
            if (p == 0) begin
                apply(s);
                model_sh = s;
            end
            if (p == junk_p) apply(junk);
            if (p == rst_p) begin
                reset_n = 1'b0;
                #1;
                check("midreset an_n", an_n, 4'hF);
                check("midreset bcd_out", bcd_out, 4'hA);
                check("midreset frame_start", {3'b000, frame_start}, 4'h0);
                return;
            end
        end
    endtask

    stim_t none;

    initial begin
        none = mk(16'h0000, 1'b0, 1'b0, 1'b0);
        apply(mk(16'h1259, 1'b0, 1'b0, 1'b0));
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset an_n", an_n, 4'hF);
        check("reset bcd_out", bcd_out, 4'hA);
        check("reset frame_start", {3'b000, frame_start}, 4'h0);
        reset_n = 1'b1;
        sync_frame();

        // Basic scan, then a mid-frame change that must wait for the next frame
        run_frame(mk(16'h1259, 1'b0, 1'b0, 1'b0), -1, none, -1);
        run_frame(mk(16'h1259, 1'b0, 1'b0, 1'b0), 10, mk(16'h0734, 1'b0, 1'b0, 1'b0), -1);
        run_frame(mk(16'h0734, 1'b0, 1'b0, 1'b0), -1, none, -1);
        // Leading-zero blanking on and off
        run_frame(mk(16'h0945, 1'b0, 1'b0, 1'b1), -1, none, -1);
        run_frame(mk(16'h0945, 1'b0, 1'b0, 1'b0), -1, none, -1);
        // AM/PM page
        run_frame(mk(16'h1259, 1'b0, 1'b1, 1'b0), -1, none, -1);
        run_frame(mk(16'h1259, 1'b1, 1'b1, 1'b0), -1, none, -1);
        // Invalid digit
        run_frame(mk(16'h1C59, 1'b0, 1'b0, 1'b0), -1, none, -1);

        // Random frames with random mid-frame input churn
        for (int f = 0; f < 20; f++) begin
            run_frame(rnd_stim(), int'($urandom_range(1, FRAME - 1)), rnd_stim(), -1);
        end

        // Reset at cnt==5 of slot 1, then restart from slot 3
        run_frame(mk(16'h2318, 1'b0, 1'b0, 1'b0), -1, none, 2 * SLOT + 5);
        repeat (2) @(negedge clk);
        check("held reset an_n", an_n, 4'hF);
        reset_n = 1'b1;
        sync_frame();
        run_frame(mk(16'h1047, 1'b1, 1'b0, 1'b1), -1, none, -1);
        run_frame(mk(16'h0000, 1'b0, 1'b0, 1'b1), -1, none, -1);
        run_frame(mk(16'h0000, 1'b0, 1'b0, 1'b1), -1, none, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
